// File: rtl/cci_arb_pkg.sv
// Shared CCI TX constants, header type and the round-robin pick used by the
// TX1 write arbiter.
package cci_arb_pkg;

   localparam int CCI_TX_HDR_W = 61;
   localparam int CCI_DATA_W   = 512;
   localparam int MAX_CLIENTS  = 16;

   typedef logic [CCI_TX_HDR_W-1:0] t_cci_tx_hdr;

   // One-hot pick of the first set bit of req at or above ptr, wrapping
   // modulo n. Bits at or above n in req are ignored.
   function automatic logic [MAX_CLIENTS-1:0] rr_pick(
      input logic [MAX_CLIENTS-1:0] req,
      input logic [3:0]             ptr,
      input logic [4:0]             n
   );
      logic [MAX_CLIENTS-1:0] pick;
      logic                   found;
      logic [4:0]             idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_CLIENTS; k++) begin
         idx = {1'b0, ptr} + 5'(k);
         if (idx >= n) begin
            idx = idx - n;
         end
         if ((5'(k) < n) && !found && req[idx[3:0]]) begin
            pick[idx[3:0]] = 1'b1;
            found          = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/cci_issue_throttle.sv
// Credit counter that lets a bounded number of writes through after TX1
// almost-full asserts, and gates all issue while the AFU is disabled.
module cci_issue_throttle
   import cci_arb_pkg::*;
#(
   parameter int AF_SLACK = 4
)(
   input  logic clk,
   input  logic reset,
   input  logic afu_en,
   input  logic almostfull,
   input  logic issue,
   output logic can_issue
);

   localparam logic [3:0] SLACK = 4'(AF_SLACK);

   logic [3:0] credit;

   // The budget is only spent while almost-full is high; any cycle with it
   // low (or with the AFU disabled) restores the full slack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         credit <= SLACK;
      end else if (!afu_en || !almostfull) begin
         credit <= SLACK;
      end else if (issue && (credit != 4'd0)) begin
         credit <= credit - 4'd1;
      end
   end

   assign can_issue = !reset && afu_en && (!almostfull || (credit != 4'd0));

endmodule

// File: rtl/cci_tx_rr_write_arbiter.sv
// N-client round-robin arbiter for the CCI TX1 write channel with an
// almost-full slack throttle and a registered header/data/valid stage.
module cci_tx_rr_write_arbiter
   import cci_arb_pkg::*;
#(
   parameter int N_CLIENTS = 2,
   parameter int HDR_W     = CCI_TX_HDR_W,
   parameter int DATA_W    = CCI_DATA_W,
   parameter int AF_SLACK  = 4
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        afu_en,
   input  logic [N_CLIENTS-1:0]        req,
   input  logic [N_CLIENTS*HDR_W-1:0]  req_hdr,
   input  logic [N_CLIENTS*DATA_W-1:0] req_data,
   output logic [N_CLIENTS-1:0]        grant,
   input  logic                        tx1_almostfull,
   output logic [HDR_W-1:0]            tx1_hdr,
   output logic [DATA_W-1:0]           tx1_data,
   output logic                        tx1_wrvalid,
   output logic [31:0]                 issue_count
);

   localparam int PTR_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

   // Handshake: req is a level request and grant is its same-cycle accept.
   // A client seeing req && grant has had hdr/data taken at the closing edge
   // and must advance; req without grant means retry, nothing is remembered.

   logic [PTR_W-1:0]       ptr;
   logic [PTR_W-1:0]       ptr_next;
   logic [MAX_CLIENTS-1:0] pick_full;
   logic [3:0]             win;
   logic                   can_issue;
   logic                   any_grant;
   logic [HDR_W-1:0]       sel_hdr;
   logic [DATA_W-1:0]      sel_data;

   always_comb begin
      pick_full = rr_pick(MAX_CLIENTS'(req), 4'(ptr), 5'(N_CLIENTS));
   end

   assign grant     = pick_full[N_CLIENTS-1:0] & {N_CLIENTS{can_issue}};
   assign any_grant = |grant;

   always_comb begin
      win = '0;
      for (int i = 0; i < MAX_CLIENTS; i++) begin
         if (pick_full[i]) begin
            win = 4'(i);
         end
      end
   end

   always_comb begin
      if (win == 4'(N_CLIENTS - 1)) begin
         ptr_next = '0;
      end else begin
         ptr_next = PTR_W'(win + 4'd1);
      end
   end

   always_comb begin
      sel_hdr  = '0;
      sel_data = '0;
      for (int i = 0; i < N_CLIENTS; i++) begin
         if (win == 4'(i)) begin
            sel_hdr  = req_hdr[i*HDR_W +: HDR_W];
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   cci_issue_throttle #(
      .AF_SLACK (AF_SLACK)
   ) u_throttle (
      .clk        (clk),
      .reset      (reset),
      .afu_en     (afu_en),
      .almostfull (tx1_almostfull),
      .issue      (any_grant),
      .can_issue  (can_issue)
   );

   // Header/data hold their last value on idle cycles; only valid drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr         <= '0;
         tx1_wrvalid <= 1'b0;
         tx1_hdr     <= '0;
         tx1_data    <= '0;
         issue_count <= '0;
      end else begin
         tx1_wrvalid <= any_grant;
         if (!afu_en) begin
            ptr <= '0;
         end else if (any_grant) begin
            ptr         <= ptr_next;
            tx1_hdr     <= sel_hdr;
            tx1_data    <= sel_data;
            issue_count <= issue_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_cci_tx_rr_write_arbiter.sv
// Directed, table-driven bench for the CCI TX1 round-robin write arbiter.
module tb_cci_tx_rr_write_arbiter;

   localparam int N  = 4;
   localparam int HW = 61;
   localparam int DW = 512;

   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic            af;
   logic            af0;
   logic [N-1:0]    req;
   logic [N*HW-1:0] req_hdr;
   logic [N*DW-1:0] req_data;

   logic [N-1:0]  grant, grant0;
   logic [HW-1:0] hdr, hdr0;
   logic [DW-1:0] data, data0;
   logic          wrvalid, wrvalid0;
   logic [31:0]   issue, issue0;

   int errors = 0;
   int checks = 0;
   int tag    = 0;

   logic [HW-1:0] exp_hdr   = '0;
   logic [DW-1:0] exp_data  = '0;
   logic [31:0]   exp_issue = '0;
   logic          exp_valid = 1'b0;

   typedef struct {
      logic [3:0] req;
      logic       af;
      logic       en;
      logic [3:0] exp_grant;
   } vec_t;

   vec_t vecs[$];

   cci_tx_rr_write_arbiter #(
      .N_CLIENTS (N), .HDR_W (HW), .DATA_W (DW), .AF_SLACK (4)
   ) dut (
      .clk (clk), .reset (rst), .afu_en (en), .req (req),
      .req_hdr (req_hdr), .req_data (req_data), .grant (grant),
      .tx1_almostfull (af), .tx1_hdr (hdr), .tx1_data (data),
      .tx1_wrvalid (wrvalid), .issue_count (issue)
   );

   cci_tx_rr_write_arbiter #(
      .N_CLIENTS (N), .HDR_W (HW), .DATA_W (DW), .AF_SLACK (0)
   ) dut0 (
      .clk (clk), .reset (rst), .afu_en (en), .req (req),
      .req_hdr (req_hdr), .req_data (req_data), .grant (grant0),
      .tx1_almostfull (af0), .tx1_hdr (hdr0), .tx1_data (data0),
      .tx1_wrvalid (wrvalid0), .issue_count (issue0)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1);
   end

   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if (!$onehot0(grant)) begin
            errors++;
            $display("FAIL grant_onehot: got %b, required at most one bit", grant);
         end
      end
   end

   function automatic logic [HW-1:0] mk_hdr(input int t, input int i);
      return HW'(t * 16 + i) | 61'h1000_0000_0000;
   endfunction

   function automatic logic [DW-1:0] mk_data(input int t, input int i);
      return {32'(t), 448'h0, 32'(i)};
   endfunction

   function automatic int oh_idx(input logic [3:0] g);
      int r;
      r = 0;
      for (int i = 0; i < 4; i++) begin
         if (g[i]) r = i;
      end
      return r;
   endfunction

   // scoreboard compare
   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic add_vec(input logic [3:0] r, input logic a, input logic e, input logic [3:0] g);
      vec_t v;
      v.req = r; v.af = a; v.en = e; v.exp_grant = g;
      vecs.push_back(v);
   endtask

   // driver: one cycle, called at posedge+1
   task automatic apply(input logic [3:0] r, input logic a, input logic e, input logic [3:0] g);
      tag++;
      for (int i = 0; i < N; i++) begin
         req_hdr[i*HW +: HW]  = mk_hdr(tag, i);
         req_data[i*DW +: DW] = mk_data(tag, i);
      end
      req = r;
      af  = a;
      en  = e;
      #1;
      chk("grant", DW'(grant), DW'(g));
      chk("grant_slack0", DW'(grant0), DW'(0));
      if (g != 4'b0000) begin
         exp_hdr   = mk_hdr(tag, oh_idx(g));
         exp_data  = mk_data(tag, oh_idx(g));
         exp_issue = exp_issue + 32'd1;
         exp_valid = 1'b1;
      end else begin
         exp_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("wrvalid", DW'(wrvalid), DW'(exp_valid));
      chk("tx1_hdr", DW'(hdr), DW'(exp_hdr));
      chk("tx1_data", data, exp_data);
      chk("issue_count", DW'(issue), DW'(exp_issue));
      chk("wrvalid_slack0", DW'(wrvalid0), DW'(0));
   endtask

   initial begin
      rst      = 1'b1;
      en       = 1'b1;
      af       = 1'b0;
      af0      = 1'b1;
      req      = 4'b1111;
      req_hdr  = '0;
      req_data = '0;

      // full rotation
      for (int k = 0; k < 2; k++) begin
         add_vec(4'b1111, 1'b0, 1'b1, 4'b0001);
         add_vec(4'b1111, 1'b0, 1'b1, 4'b0010);
         add_vec(4'b1111, 1'b0, 1'b1, 4'b0100);
         add_vec(4'b1111, 1'b0, 1'b1, 4'b1000);
      end
      // sparse requesters 0 and 2
      for (int k = 0; k < 2; k++) begin
         add_vec(4'b0101, 1'b0, 1'b1, 4'b0001);
         add_vec(4'b0101, 1'b0, 1'b1, 4'b0100);
      end
      // almost-full with slack 4, from ptr=3
      add_vec(4'b1111, 1'b1, 1'b1, 4'b1000);
      add_vec(4'b1111, 1'b1, 1'b1, 4'b0001);
      add_vec(4'b1111, 1'b1, 1'b1, 4'b0010);
      add_vec(4'b1111, 1'b1, 1'b1, 4'b0100);
      for (int k = 0; k < 6; k++) add_vec(4'b1111, 1'b1, 1'b1, 4'b0000);
      // almost-full falls: issue in that same cycle
      add_vec(4'b1111, 1'b0, 1'b1, 4'b1000);
      add_vec(4'b0000, 1'b0, 1'b1, 4'b0000);
      add_vec(4'b1111, 1'b0, 1'b1, 4'b0001);
      // afu_en low resets ptr and reloads credit even under almost-full
      add_vec(4'b1111, 1'b1, 1'b1, 4'b0010);
      add_vec(4'b1111, 1'b1, 1'b0, 4'b0000);
      add_vec(4'b1111, 1'b1, 1'b1, 4'b0001);
      add_vec(4'b1111, 1'b1, 1'b1, 4'b0010);
      add_vec(4'b1111, 1'b1, 1'b1, 4'b0100);
      add_vec(4'b1111, 1'b1, 1'b1, 4'b1000);
      add_vec(4'b1111, 1'b1, 1'b1, 4'b0000);
      // mixed patterns and skipped/dropped requesters
      add_vec(4'b1010, 1'b0, 1'b1, 4'b0010);
      add_vec(4'b1010, 1'b0, 1'b1, 4'b1000);
      add_vec(4'b1010, 1'b0, 1'b1, 4'b0010);
      add_vec(4'b1000, 1'b0, 1'b1, 4'b1000);
      add_vec(4'b0110, 1'b0, 1'b1, 4'b0010);
      add_vec(4'b0110, 1'b0, 1'b1, 4'b0100);
      add_vec(4'b0110, 1'b0, 1'b1, 4'b0010);

      // reset state, with every client requesting
      #7;
      chk("rst_grant", DW'(grant), DW'(0));
      chk("rst_wrvalid", DW'(wrvalid), DW'(0));
      chk("rst_hdr", DW'(hdr), DW'(0));
      chk("rst_data", data, DW'(0));
      chk("rst_issue", DW'(issue), DW'(0));
      @(negedge clk);
      req = 4'b0000;
      rst = 1'b0;
      @(posedge clk);
      #1;

      foreach (vecs[v]) begin
         apply(vecs[v].req, vecs[v].af, vecs[v].en, vecs[v].exp_grant);
      end

      // reset in the cycle after a grant drops the registered write at once
      apply(4'b1111, 1'b0, 1'b1, 4'b0100);
      rst = 1'b1;
      #1;
      chk("midrst_wrvalid", DW'(wrvalid), DW'(0));
      chk("midrst_grant", DW'(grant), DW'(0));
      chk("midrst_issue", DW'(issue), DW'(0));
      chk("midrst_hdr", DW'(hdr), DW'(0));
      exp_hdr   = '0;
      exp_data  = '0;
      exp_issue = '0;
      @(negedge clk);
      req = 4'b0000;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // three grants, one disabled cycle, then rotation restarts at client 0
      apply(4'b1111, 1'b0, 1'b1, 4'b0001);
      apply(4'b1111, 1'b0, 1'b1, 4'b0010);
      apply(4'b1111, 1'b0, 1'b1, 4'b0100);
      apply(4'b1111, 1'b0, 1'b0, 4'b0000);
      chk("disabled_issue_hold", DW'(issue), DW'(3));
      apply(4'b1111, 1'b0, 1'b1, 4'b0001);
      // slack restored after reset: four grants under almost-full
      apply(4'b1111, 1'b1, 1'b1, 4'b0010);
      apply(4'b1111, 1'b1, 1'b1, 4'b0100);
      apply(4'b1111, 1'b1, 1'b1, 4'b1000);
      apply(4'b1111, 1'b1, 1'b1, 4'b0001);
      apply(4'b1111, 1'b1, 1'b1, 4'b0000);

      // issue_count wrap
      req = 4'b0000;
      force dut.issue_count = 32'hFFFF_FFFE;
      #1;
      release dut.issue_count;
      exp_issue = 32'hFFFF_FFFE;
      apply(4'b1111, 1'b0, 1'b1, 4'b0010);
      apply(4'b1111, 1'b0, 1'b1, 4'b0100);
      chk("wrap_zero", DW'(issue), DW'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
